// File: rtl/main_memory_model.sv
// Word-addressed backing store below the L2: one request at a time, fixed access latency,
// back-pressurable response channel, deterministic reset contents and saturating statistics.
module main_memory_model #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned INIT_XOR   = 32'h3F3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_write,
  output logic                  busy,
  output logic [15:0]           read_count,
  output logic [15:0]           write_count
);

  localparam int unsigned CntW = $clog2(LATENCY) + 1;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_write_q, resp_write_d;
  logic [15:0]           read_count_q, read_count_d;
  logic [15:0]           write_count_q, write_count_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  in_range;
  logic                  mem_we;
  logic [IdxW-1:0]       mem_idx;

  function automatic logic [DATA_WIDTH-1:0] init_word(input int unsigned a);
    return DATA_WIDTH'(a ^ INIT_XOR);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Addresses beyond the implemented depth read as zero and swallow writes.
  assign in_range = 32'(addr_q) < DEPTH;
  assign mem_idx  = IdxW'(addr_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    write_d       = write_q;
    resp_rdata_d  = resp_rdata_q;
    resp_write_d  = resp_write_q;
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    mem_we        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          cnt_d   = CntW'(LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d      = StResp;
          resp_write_d = write_q;
          if (write_q) begin
            resp_rdata_d = wdata_q;
            mem_we       = in_range;
          end else begin
            resp_rdata_d = in_range ? mem_q[mem_idx] : '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
          if (resp_write_q) begin
            write_count_d = sat_inc(write_count_q);
          end else begin
            read_count_d = sat_inc(read_count_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      resp_rdata_q  <= '0;
      resp_write_q  <= 1'b0;
      read_count_q  <= '0;
      write_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      write_q       <= write_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_write_q  <= resp_write_d;
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
    end
  end

  // Reset restores every word to its init pattern, so the array needs async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[IdxW'(i)] <= init_word(i);
      end
    end else if (mem_we) begin
      mem_q[mem_idx] <= wdata_q;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign resp_valid  = (state_q == StResp);
  assign busy        = (state_q != StIdle);
  assign resp_rdata  = resp_rdata_q;
  assign resp_write  = resp_write_q;
  assign read_count  = read_count_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_main_memory_model.sv
// Bench for main_memory_model: a default instance (LATENCY=4, full depth) and a
// reduced instance (LATENCY=1, DEPTH=1024), both checked against an array-based model.
module tb_main_memory_model;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel;
  logic          req_valid, req_write, resp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          req_valid_a, req_ready_a, resp_valid_a, resp_write_a, busy_a;
  logic          req_valid_b, req_ready_b, resp_valid_b, resp_write_b, busy_b;
  logic [DW-1:0] resp_rdata_a, resp_rdata_b;
  logic [15:0]   rc_a, wc_a, rc_b, wc_b;

  logic          req_ready, resp_valid, resp_write, busy;
  logic [DW-1:0] resp_rdata;
  logic [15:0]   read_count, write_count;

  assign req_valid_a = req_valid && !sel;
  assign req_valid_b = req_valid && sel;
  assign req_ready   = sel ? req_ready_b  : req_ready_a;
  assign resp_valid  = sel ? resp_valid_b : resp_valid_a;
  assign resp_write  = sel ? resp_write_b : resp_write_a;
  assign resp_rdata  = sel ? resp_rdata_b : resp_rdata_a;
  assign busy        = sel ? busy_b       : busy_a;
  assign read_count  = sel ? rc_b         : rc_a;
  assign write_count = sel ? wc_b         : wc_a;

  main_memory_model dut_a (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid_a),
    .req_ready  (req_ready_a),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid_a),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata_a),
    .resp_write (resp_write_a),
    .busy       (busy_a),
    .read_count (rc_a),
    .write_count(wc_a)
  );

  main_memory_model #(
    .DEPTH  (1024),
    .LATENCY(1)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid_b),
    .req_ready  (req_ready_b),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid_b),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata_b),
    .resp_write (resp_write_b),
    .busy       (busy_b),
    .read_count (rc_b),
    .write_count(wc_b)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain arrays per instance plus counters.
  logic [DW-1:0] mdl_mem [2][2048];
  int            mdl_rc [2];
  int            mdl_wc [2];
  int            lat_m  [2] = '{4, 1};
  int            dep_m  [2] = '{2048, 1024};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 2048; a++) mdl_mem[s][a] = DW'(a ^ 'h3F3);
      mdl_rc[s] = 0;
      mdl_wc[s] = 0;
    end
  endtask

  // Runs one transaction on instance s; expects to start at a negedge with the DUT idle.
  task automatic do_txn(input bit s, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int stall, output int acc_cyc);
    logic [DW-1:0] exp;
    sel = s;
    if (int'(a) < dep_m[s]) begin
      if (w) begin
        mdl_mem[s][a] = d;
        exp = d;
      end else begin
        exp = mdl_mem[s][a];
      end
    end else begin
      exp = w ? d : '0;
    end
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = (stall == 0);
    @(negedge clk);
    acc_cyc   = cycle;
    req_valid = 1'b0;
    check_eq("req_ready_busy", 32'(req_ready), 32'd0);
    check_eq("busy", 32'(busy), 32'd1);
    for (int k = 1; k <= lat_m[s]; k++) begin
      if (k > 1) @(negedge clk);
      if (k == lat_m[s]) @(negedge clk);
      else begin
        check_eq("resp_valid_early", 32'(resp_valid), 32'd0);
      end
    end
    if (lat_m[s] == 1) begin
      // for LATENCY=1 the loop above already advanced exactly one edge
    end
    check_eq("resp_valid_rise", 32'(resp_valid), 32'd1);
    check_eq("resp_rdata", 32'(resp_rdata), 32'(exp));
    check_eq("resp_write", 32'(resp_write), 32'(w));
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = AW'($urandom_range(0, 2047));
      req_wdata = DW'($urandom);
      @(negedge clk);
      check_eq("stall_valid", 32'(resp_valid), 32'd1);
      check_eq("stall_rdata", 32'(resp_rdata), 32'(exp));
      check_eq("stall_write", 32'(resp_write), 32'(w));
      check_eq("stall_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    if (w) mdl_wc[s] = (mdl_wc[s] == 'hFFFF) ? mdl_wc[s] : mdl_wc[s] + 1;
    else   mdl_rc[s] = (mdl_rc[s] == 'hFFFF) ? mdl_rc[s] : mdl_rc[s] + 1;
    @(negedge clk);
    check_eq("resp_valid_fall", 32'(resp_valid), 32'd0);
    check_eq("read_count", 32'(read_count), 32'(mdl_rc[s]));
    check_eq("write_count", 32'(write_count), 32'(mdl_wc[s]));
  endtask

  initial begin
    int acc, prev;
    logic [AW-1:0] ra;
    bit s, w;
    rst        = 1'b1;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready_a", 32'(req_ready_a), 32'd1);
    check_eq("rst_req_ready_b", 32'(req_ready_b), 32'd1);
    check_eq("rst_resp_valid_a", 32'(resp_valid_a), 32'd0);
    check_eq("rst_busy_a", 32'(busy_a), 32'd0);
    check_eq("rst_rdata_a", 32'(resp_rdata_a), 32'd0);
    check_eq("rst_counts_a", {rc_a, wc_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic read, write-then-read at the top address, back-pressured read.
    do_txn(1'b0, 1'b0, 11'h005, 11'h000, 0, acc);
    do_txn(1'b0, 1'b1, 11'h7FF, 11'h155, 0, acc);
    do_txn(1'b0, 1'b0, 11'h7FF, 11'h000, 0, acc);
    do_txn(1'b0, 1'b0, 11'h010, 11'h000, 3, acc);
    do_txn(1'b0, 1'b0, 11'h005, 11'h000, 2, acc);

    // Reset while a write sits in WAIT: no response, memory and counters restored.
    sel       = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 11'h020;
    req_wdata = 11'h0AA;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_resp_valid", 32'(resp_valid_a), 32'd0);
    check_eq("midrst_req_ready", 32'(req_ready_a), 32'd1);
    check_eq("midrst_counts", {rc_a, wc_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("postrst_no_resp", 32'(resp_valid_a), 32'd0);
    end
    do_txn(1'b0, 1'b0, 11'h020, 11'h000, 0, acc);

    // Reduced-depth instance: out-of-range reads zero, writes dropped but echoed.
    do_txn(1'b1, 1'b0, 11'h400, 11'h000, 0, acc);
    do_txn(1'b1, 1'b1, 11'h400, 11'h123, 0, acc);
    do_txn(1'b1, 1'b0, 11'h000, 11'h000, 0, acc);
    do_txn(1'b1, 1'b0, 11'h400, 11'h000, 1, acc);

    // LATENCY=1 back-to-back with resp_ready high: acceptances three cycles apart.
    do_txn(1'b1, 1'b1, 11'h055, 11'h2AA, 0, prev);
    for (int i = 0; i < 6; i++) begin
      do_txn(1'b1, 1'($urandom), AW'($urandom_range(0, 127)), DW'($urandom), 0, acc);
      check_eq("b2b_spacing", 32'(acc - prev), 32'd3);
      prev = acc;
    end

    // Random mix across both instances.
    for (int i = 0; i < 80; i++) begin
      s  = 1'($urandom);
      w  = 1'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31) + 'h3F0);
      do_txn(s, w, ra, DW'($urandom), $urandom_range(0, 2), acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
